upower_multicycle_ctrl: RTL and testbench

//  Fetch/decode/control stage upstream of the uPower load/store/ALU datapath.
//  - Holds the PC and instruction register (IR), and fetches each word from a combinational instruction memory.
//  - Sequences every instruction through a multi-cycle FSM.
//  - Drives instruction, ALU_OP, RegWrite, MemRead and MemWrite into the datapath, with a ready handshake to data memory.

---
 rtl/upower_multicycle_ctrl_if.sv | 68 ++++++
 rtl/upower_multicycle_ctrl.sv | 177 +++++++++++++++++
 tb/tb_upower_multicycle_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/upower_multicycle_ctrl_if.sv
// ----------------------------------------------------------------------------
// upower_multicycle_ctrl_if
//   Bundles the instruction-memory port, the data-memory handshake and the
//   control bus driven into the uPower datapath.
//
//   master : the controller (drives addresses, IR and control strobes)
//   slave  : memory/datapath side (returns imem_data and mem_ready)
//
//   Signals:
//     imem_addr    N  instruction memory address (always equals pc)
//     imem_data    N  instruction word at imem_addr (combinational)
//     mem_ready    1  data memory completed the current access
//     instruction  N  IR contents
//     ALU_OP       4  ALU operation code
//     RegWrite     1  register file write enable
//     MemRead      1  data memory read request
//     MemWrite     1  data memory write request
//     pc           N  current program counter
//     instr_done   1  pulse on the final cycle of each instruction
//     halted       1  sticky, controller stopped
//     illegal      1  sticky, stopped on an undecodable instruction
// ----------------------------------------------------------------------------
interface upower_multicycle_ctrl_if #(
    parameter int N = 32
);
    logic [N-1:0] imem_addr;
    logic [N-1:0] imem_data;
    logic         mem_ready;
    logic [N-1:0] instruction;
    logic [3:0]   ALU_OP;
    logic         RegWrite;
    logic         MemRead;
    logic         MemWrite;
    logic [N-1:0] pc;
    logic         instr_done;
    logic         halted;
    logic         illegal;

    modport master (
        output imem_addr,
        input  imem_data,
        input  mem_ready,
        output instruction,
        output ALU_OP,
        output RegWrite,
        output MemRead,
        output MemWrite,
        output pc,
        output instr_done,
        output halted,
        output illegal
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output mem_ready,
        input  instruction,
        input  ALU_OP,
        input  RegWrite,
        input  MemRead,
        input  MemWrite,
        input  pc,
        input  instr_done,
        input  halted,
        input  illegal
    );
endinterface

// File: rtl/upower_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// upower_multicycle_ctrl
//   Fetch/decode/control stage for the uPower load/store/ALU datapath.
//   Holds PC and IR, fetches from a combinational instruction memory and
//   walks every instruction through FETCH, DECODE, EXEC, [MEM], [WB].
//
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     bus        upower_multicycle_ctrl_if.master (memory + control bus)
//     state_dbg  current FSM state, for observation only
//
//   Data-memory handshake: MemRead/MemWrite act as the request "valid" and
//   stay high every cycle the FSM sits in MEM; mem_ready is the "ready".
//   The access completes on the rising edge where both are high; mem_ready
//   is ignored whenever no request is outstanding.
// ----------------------------------------------------------------------------
module upower_multicycle_ctrl #(
    parameter int           N        = 32,
    parameter logic [N-1:0] PC_RESET = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    upower_multicycle_ctrl_if.master  bus,
    output logic [2:0]                state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        C_LOAD  = 2'd0,
        C_STORE = 2'd1,
        C_ALU   = 2'd2
    } cls_t;

    state_t       state;
    cls_t         cls_q;
    logic [N-1:0] pc_q;
    logic [N-1:0] ir_q;
    logic [3:0]   alu_op_q;
    logic         reg_write_q;
    logic         mem_read_q;
    logic         mem_write_q;
    logic         halted_q;
    logic         illegal_q;

    // Decode of the held IR
    logic [5:0] opcode;
    logic [9:0] xo;
    logic       dec_legal;
    logic       dec_zero;
    cls_t       dec_cls;
    logic [3:0] dec_alu;

    assign opcode = ir_q[31:26];
    assign xo     = ir_q[10:1];

    always_comb begin
        dec_legal = 1'b0;
        dec_zero  = (ir_q == '0);
        dec_cls   = C_ALU;
        dec_alu   = 4'b0000;
        case (opcode)
            6'd32: begin dec_legal = 1'b1; dec_cls = C_LOAD;  dec_alu = 4'b0010; end
            6'd36: begin dec_legal = 1'b1; dec_cls = C_STORE; dec_alu = 4'b0010; end
            6'd14: begin dec_legal = 1'b1; dec_cls = C_ALU;   dec_alu = 4'b0010; end
            6'd31: begin
                case (xo)
                    10'd266: begin dec_legal = 1'b1; dec_alu = 4'b0010; end
                    10'd40:  begin dec_legal = 1'b1; dec_alu = 4'b0110; end
                    10'd28:  begin dec_legal = 1'b1; dec_alu = 4'b0000; end
                    10'd444: begin dec_legal = 1'b1; dec_alu = 4'b0001; end
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Enables are registered on the transition into the state that owns
    // them, so they are glitch-free and line up exactly with MEM/WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            cls_q       <= C_ALU;
            pc_q        <= PC_RESET;
            ir_q        <= '0;
            alu_op_q    <= 4'b0000;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir_q  <= bus.imem_data;
                    pc_q  <= pc_q + N'(4);
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    if (dec_legal) begin
                        cls_q    <= dec_cls;
                        alu_op_q <= dec_alu;
                        state    <= S_EXEC;
                    end else begin
                        // An all-zero word is the intended stop marker.
                        halted_q  <= 1'b1;
                        illegal_q <= !dec_zero;
                        state     <= S_HALT;
                    end
                end
                S_EXEC: begin
                    if (cls_q == C_ALU) begin
                        reg_write_q <= 1'b1;
                        state       <= S_WB;
                    end else begin
                        mem_read_q  <= (cls_q == C_LOAD);
                        mem_write_q <= (cls_q == C_STORE);
                        state       <= S_MEM;
                    end
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (cls_q == C_LOAD) begin
                            reg_write_q <= 1'b1;
                            state       <= S_WB;
                        end else begin
                            alu_op_q <= 4'b0000;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    reg_write_q <= 1'b0;
                    alu_op_q    <= 4'b0000;
                    state       <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instruction = ir_q;
    assign bus.ALU_OP      = alu_op_q;
    assign bus.RegWrite    = reg_write_q;
    assign bus.MemRead     = mem_read_q;
    assign bus.MemWrite    = mem_write_q;
    assign bus.halted      = halted_q;
    assign bus.illegal     = illegal_q;

    // A store finishes in the MEM cycle whose edge sees mem_ready, so its
    // done pulse must follow mem_ready combinationally; a reset in that
    // cycle aborts the store and suppresses the pulse.
    assign bus.instr_done  = reg_write_q |
                             ((state == S_MEM) && (cls_q == C_STORE) &&
                              bus.mem_ready && !rst);

    assign state_dbg = state;

endmodule

// File: tb/tb_upower_multicycle_ctrl.sv
module tb_upower_multicycle_ctrl;
    localparam int N = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rst_w;
    logic        mem_ready;
    logic        imem_x;
    logic [31:0] imem [0:63];
    logic [2:0]  state_dbg;
    logic [2:0]  state_dbg_w;

    upower_multicycle_ctrl_if #(.N(N)) mbus ();
    upower_multicycle_ctrl_if #(.N(N)) wbus ();

    assign mbus.imem_data = imem_x ? {N{1'bx}} : imem[mbus.imem_addr[7:2]];
    assign mbus.mem_ready = mem_ready;
    assign wbus.imem_data = imem[wbus.imem_addr[7:2]];
    assign wbus.mem_ready = 1'b1;

    upower_multicycle_ctrl #(.N(N), .PC_RESET(32'h0000_0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (mbus),
        .state_dbg (state_dbg)
    );

    upower_multicycle_ctrl #(.N(N), .PC_RESET(32'hFFFF_FFFC)) u_wrap (
        .clk       (clk),
        .rst       (rst_w),
        .bus       (wbus),
        .state_dbg (state_dbg_w)
    );

    // ------------------------------------------------------------------
    // Reference model: each instruction expands into a list of expected
    // cycles (what the bus must show during that cycle).
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        rdy;
        logic        chk_alu;
        logic [3:0]  alu;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        done;
        logic [31:0] pc;
    } step_t;

    step_t       exp_q[$];
    logic [31:0] exp_pc;
    int          n_cmp  = 0;
    int          n_fail = 0;

    // kind: 0 load, 1 store, 2 alu, 3 normal halt, 4 illegal
    function automatic void model_decode(input logic [31:0] w, output int kind,
                                         output logic [3:0] alu);
        logic [5:0] op;
        logic [9:0] x;
        op   = w[31:26];
        x    = w[10:1];
        kind = 4;
        alu  = 4'b0000;
        if (w == 32'h0)      kind = 3;
        else if (op == 6'd32) begin kind = 0; alu = 4'b0010; end
        else if (op == 6'd36) begin kind = 1; alu = 4'b0010; end
        else if (op == 6'd14) begin kind = 2; alu = 4'b0010; end
        else if (op == 6'd31) begin
            if (x == 10'd266)      begin kind = 2; alu = 4'b0010; end
            else if (x == 10'd40)  begin kind = 2; alu = 4'b0110; end
            else if (x == 10'd28)  begin kind = 2; alu = 4'b0000; end
            else if (x == 10'd444) begin kind = 2; alu = 4'b0001; end
        end
    endfunction

    function automatic void push(input logic rdy, input logic chk, input logic [3:0] alu,
                                 input logic rw, input logic mr, input logic mw,
                                 input logic done, input logic [31:0] pc);
        step_t s;
        s.rdy = rdy; s.chk_alu = chk; s.alu = alu;
        s.rw = rw; s.mr = mr; s.mw = mw; s.done = done; s.pc = pc;
        exp_q.push_back(s);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void plan(input logic [31:0] w, input int stalls);
        int         kind;
        logic [3:0] alu;
        logic       ld;
        logic       st;
        model_decode(w, kind, alu);
        ld = (kind == 0);
        st = (kind == 1);
        push(rnd_bit(), 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, exp_pc);   // fetch
        exp_pc = exp_pc + 32'd4;
        push(rnd_bit(), 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, exp_pc);   // decode
        if (kind >= 3) return;
        push(rnd_bit(), 1'b1, alu, 1'b0, 1'b0, 1'b0, 1'b0, exp_pc);    // exec
        if (ld || st) begin
            for (int i = 0; i < stalls; i++)
                push(1'b0, 1'b1, alu, 1'b0, ld, st, 1'b0, exp_pc);
            push(1'b1, 1'b1, alu, 1'b0, ld, st, st, exp_pc);
        end
        if (!st)
            push(rnd_bit(), 1'b1, alu, 1'b1, 1'b0, 1'b0, 1'b1, exp_pc); // writeback
    endfunction

    function automatic logic [31:0] xform(input logic [9:0] x);
        logic [31:0] b;
        b = $urandom;
        return {6'd31, b[25:11], x, b[0]};
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [31:0] b;
        b = $urandom;
        case ($urandom_range(0, 6))
            0: return {6'd32, b[25:0]};
            1: return {6'd36, b[25:0]};
            2: return {6'd14, b[25:0]};
            3: return xform(10'd266);
            4: return xform(10'd40);
            5: return xform(10'd28);
            default: return xform(10'd444);
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks (entered and left #1 after a rising edge)
    // ------------------------------------------------------------------
    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_pc = 32'h0;
        exp_q.delete();
    endtask

    task automatic run_steps(input string name, input int n);
        step_t s;
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            s = exp_q.pop_front();
            mem_ready = s.rdy;
            @(negedge clk);
            n_cmp++;
            if ({mbus.RegWrite, mbus.MemRead, mbus.MemWrite, mbus.instr_done, mbus.pc, mbus.imem_addr}
                !== {s.rw, s.mr, s.mw, s.done, s.pc, s.pc}) begin
                n_fail++;
                $display("FAIL %s cycle %0d: rw/mr/mw/done=%b%b%b%b pc=%h addr=%h, required %b%b%b%b pc=%h",
                         name, i, mbus.RegWrite, mbus.MemRead, mbus.MemWrite, mbus.instr_done,
                         mbus.pc, mbus.imem_addr, s.rw, s.mr, s.mw, s.done, s.pc);
            end
            if (s.chk_alu) begin
                n_cmp++;
                if (mbus.ALU_OP !== s.alu) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d alu_op: got %b, required %b", name, i, mbus.ALU_OP, s.alu);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_all(input string name);
        run_steps(name, exp_q.size());
    endtask

    task automatic check_halt(input string name, input logic exp_ill, input logic [31:0] pc, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            mem_ready = rnd_bit();
            @(negedge clk);
            n_cmp++;
            if ({mbus.halted, mbus.illegal, mbus.RegWrite, mbus.MemRead, mbus.MemWrite, mbus.instr_done, mbus.pc}
                !== {1'b1, exp_ill, 4'b0000, pc}) begin
                n_fail++;
                $display("FAIL %s cycle %0d: halted/illegal/en/done=%b%b%b%b%b%b pc=%h, required 1%b0000 pc=%h",
                         name, i, mbus.halted, mbus.illegal, mbus.RegWrite, mbus.MemRead, mbus.MemWrite,
                         mbus.instr_done, mbus.pc, exp_ill, pc);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        imem[0] = {6'd14, 26'h0123456};
        imem_x = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({mbus.pc, mbus.ALU_OP, mbus.RegWrite, mbus.MemRead, mbus.MemWrite, mbus.instr_done,
                 mbus.halted, mbus.illegal, mbus.instruction} !== {32'h0, 4'h0, 6'b000000, 32'h0}) begin
                n_fail++;
                $display("FAIL reset cycle %0d: pc=%h alu=%b en/done/halt/ill=%b%b%b%b%b%b ir=%h, required all zero",
                         i, mbus.pc, mbus.ALU_OP, mbus.RegWrite, mbus.MemRead, mbus.MemWrite,
                         mbus.instr_done, mbus.halted, mbus.illegal, mbus.instruction);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        imem_x = 1'b0;
        exp_pc = 32'h0;
        exp_q.delete();
        // First cycle after release must be a fetch from PC_RESET.
        plan(imem[0], 0);
        run_all("reset_release");
    endtask

    task automatic test_lwz();
        imem[0] = 32'h8041_0001;
        imem[1] = 32'h0;
        do_reset();
        plan(imem[0], 0);
        run_all("lwz");
        @(negedge clk);
        n_cmp++;
        if (mbus.instruction !== 32'h8041_0001) begin
            n_fail++;
            $display("FAIL lwz instruction: got %h, required 80410001", mbus.instruction);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stw_stall();
        imem[0] = 32'h9041_0004;
        imem[1] = 32'h0;
        do_reset();
        plan(imem[0], 3);
        plan(imem[1], 0);
        run_all("stw_stall");
        check_halt("stw_then_halt", 1'b0, 32'h8, 2);
    endtask

    task automatic test_subf_or();
        imem[0] = xform(10'd40);
        imem[1] = xform(10'd444);
        imem[2] = 32'h0;
        do_reset();
        plan(imem[0], 0);
        plan(imem[1], 0);
        plan(imem[2], 0);
        run_all("subf_or");
        check_halt("subf_or_halt", 1'b0, 32'hC, 1);
    endtask

    task automatic test_illegal();
        logic [31:0] words [3];
        logic [31:0] b;
        int          kind;
        logic [3:0]  alu;
        b = $urandom;
        words[0] = {6'b000001, b[25:0]};
        words[1] = xform(10'd123);
        words[2] = 32'h0;
        for (int k = 0; k < 3; k++) begin
            imem[0] = words[k];
            do_reset();
            model_decode(words[k], kind, alu);
            plan(words[k], 0);
            run_all("illegal_decode");
            check_halt("illegal_hold", (kind == 4), 32'h4, 4);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) imem[i] = rand_legal();
        imem[24] = 32'h0;
        do_reset();
        for (int i = 0; i < 25; i++) plan(imem[i], $urandom_range(0, 3));
        run_all("random");
        check_halt("random_halt", 1'b0, 32'd100, 2);
    endtask

    task automatic test_midop_reset();
        imem[0] = 32'h8041_0001;
        imem[1] = 32'h0;
        do_reset();
        plan(imem[0], 5);
        run_steps("midop_pre", 4);          // fetch, decode, exec, first stalled MEM
        rst = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_pc = 32'h0;
        // No enable may follow the abort; the restart refetches from 0.
        plan(imem[0], 0);
        run_all("midop_restart");
    endtask

    task automatic test_wrap();
        imem[63] = {6'd14, 26'h2AAAAAA};
        imem[0]  = 32'h0;
        rst_w = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({wbus.pc, wbus.imem_addr} !== {32'hFFFF_FFFC, 32'hFFFF_FFFC}) begin
            n_fail++;
            $display("FAIL wrap_start: pc=%h addr=%h, required fffffffc", wbus.pc, wbus.imem_addr);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({wbus.pc, wbus.instruction} !== {32'h0, imem[63]}) begin
            n_fail++;
            $display("FAIL wrap_after_fetch: pc=%h ir=%h, required pc=00000000 ir=%h",
                     wbus.pc, wbus.instruction, imem[63]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        rst_w = 1'b1;
        mem_ready = 1'b0;
        imem_x = 1'b0;
        exp_pc = 32'h0;
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_lwz();
        test_stw_stall();
        test_subf_or();
        test_illegal();
        test_random();
        test_midop_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
